rom_port_arbiter: RTL and testbench

ROM_PORT_ARBITER -- requirements
Module: rom_port_arbiter

---
 rtl/rom_port_arbiter_pkg.sv | 25 ++
 rtl/rom_port_arbiter_rr_arb2.sv | 21 ++
 rtl/rom_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_rom_port_arbiter.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/rom_port_arbiter_pkg.sv
// Shared definitions for the ROM port arbiter: FSM state and owner encodings
// plus the sizing rule for the optional WAIT timeout counter.
package rom_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StResp = 2'd2
    } state_e;

    typedef enum logic {
        OwnIf = 1'b0,
        OwnLs = 1'b1
    } owner_e;

    localparam int unsigned MinCntW = 8;

    // Timeout counter width: wide enough to hold TIMEOUT, never narrower than 8 bits.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        int unsigned w;
        w = $clog2(timeout + 1);
        return (w > MinCntW) ? w : MinCntW;
    endfunction

endpackage

// File: rtl/rom_port_arbiter_rr_arb2.sv
// Two-way round-robin selector: a lone request wins, a tie goes to the port
// that was not granted last.
module rr_arb2
    import rom_port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  owner_e     last,
    output owner_e     grant
);

    // Pick the owner from the current request pair and the previous grant.
    always_comb begin
        grant = OwnIf;
        if (req == 2'b11) begin
            grant = (last == OwnIf) ? OwnLs : OwnIf;
        end else if (req[1]) begin
            grant = OwnLs;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Shares one multi-cycle ROM reader between the instruction-fetch and
// data-load ports. Define ROM_ARB_TIMEOUT_EN to bound WAIT at TIMEOUT cycles
// (aborted reads return zero and pulse err with the ack).
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [31:0]       if_rdata,
    input  logic              ls_req,
    input  logic [ADDR_W-1:0] ls_addr,
    output logic              ls_ack,
    output logic [31:0]       ls_rdata,
    output logic              read_ce,
    output logic [ADDR_W-1:0] address,
    input  logic [31:0]       dout,
    input  logic              rfin,
    output logic              busy,
    output logic              err
);

    state_e            state_q;
    owner_e            owner_q;
    owner_e            last_q;
    owner_e            grant;
    logic [ADDR_W-1:0] address_q;
    logic [ADDR_W-1:0] sel_addr;
    logic              read_ce_q;
    logic              if_ack_q;
    logic              ls_ack_q;
    logic [31:0]       if_rdata_q;
    logic [31:0]       ls_rdata_q;
    logic              abort;
    logic [31:0]       wait_data;

    // Byte offsets are dropped; the ROM is word addressed.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], ls_addr[1:0]};

    rr_arb2 u_rr_arb2 (
        .req   ({ls_req, if_req}),
        .last  (last_q),
        .grant (grant)
    );

    assign sel_addr = (grant == OwnLs) ? ls_addr : if_addr;

`ifdef ROM_ARB_TIMEOUT_EN
    localparam int unsigned CntW = cnt_width(TIMEOUT);

    logic [CntW-1:0] cnt_q;
    logic            err_q;

    // rfin on the last allowed cycle still completes normally.
    assign abort = (state_q == StWait) && !rfin && (cnt_q == CntW'(TIMEOUT - 1));
    assign err   = err_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign abort          = 1'b0;
    assign err            = 1'b0;
`endif

    assign wait_data = abort ? 32'h0000_0000 : dout;

    // Transaction FSM: grant in IDLE, hold read_ce through WAIT, ack in RESP.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= StIdle;
            owner_q    <= OwnIf;
            last_q     <= OwnIf;
            address_q  <= '0;
            read_ce_q  <= 1'b0;
            if_ack_q   <= 1'b0;
            ls_ack_q   <= 1'b0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
`ifdef ROM_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            if_ack_q <= 1'b0;
            ls_ack_q <= 1'b0;
`ifdef ROM_ARB_TIMEOUT_EN
            err_q    <= 1'b0;
`endif
            unique case (state_q)
                StIdle: begin
                    if (if_req || ls_req) begin
                        owner_q   <= grant;
                        last_q    <= grant;
                        address_q <= {sel_addr[ADDR_W-1:2], 2'b00};
                        read_ce_q <= 1'b1;
                        state_q   <= StWait;
`ifdef ROM_ARB_TIMEOUT_EN
                        cnt_q     <= '0;
`endif
                    end
                end
                StWait: begin
                    if (rfin || abort) begin
                        if (owner_q == OwnLs) begin
                            ls_rdata_q <= wait_data;
                            ls_ack_q   <= 1'b1;
                        end else begin
                            if_rdata_q <= wait_data;
                            if_ack_q   <= 1'b1;
                        end
                        read_ce_q <= 1'b0;
                        state_q   <= StResp;
`ifdef ROM_ARB_TIMEOUT_EN
                        err_q     <= abort;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
`endif
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign if_ack   = if_ack_q;
    assign ls_ack   = ls_ack_q;
    assign if_rdata = if_rdata_q;
    assign ls_rdata = ls_rdata_q;
    assign read_ce  = read_ce_q;
    assign address  = address_q;
    assign busy     = (state_q != StIdle);

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter: directed scenarios plus a randomized
// phase, checked against a transaction-level model of grants and read data.
module tb_rom_port_arbiter;

`ifdef ROM_ARB_TIMEOUT_EN
    localparam int unsigned TO = 4;
`else
    localparam int unsigned TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        ls_req = 1'b0;
    logic [31:0] ls_addr = '0;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic        read_ce;
    logic [31:0] address;
    logic [31:0] dout = '0;
    logic        rfin = 1'b0;
    logic        busy;
    logic        err;

    int n_vec = 0;
    int n_bad = 0;

    // Model state: which port won last, and what each rdata should hold.
    bit          exp_last = 1'b0;  // 0 = if, 1 = ls
    logic [31:0] exp_rdata [2];
    bit          grants [$];

    rom_port_arbiter #(.ADDR_W(32), .TIMEOUT(TO)) dut (
        .clk      (clk),
        .rst      (rst),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_ack   (if_ack),
        .if_rdata (if_rdata),
        .ls_req   (ls_req),
        .ls_addr  (ls_addr),
        .ls_ack   (ls_ack),
        .ls_rdata (ls_rdata),
        .read_ce  (read_ce),
        .address  (address),
        .dout     (dout),
        .rfin     (rfin),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_read_ce"}, read_ce, 0);
        check({tag, "_address"}, address, 0);
        check({tag, "_acks"}, {if_ack, ls_ack}, 0);
        check({tag, "_rdata"}, {if_rdata, ls_rdata}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
    endtask

    // Hold reset across a couple of edges; model returns to its reset view.
    task automatic do_reset();
        rst    = 1'b0;
        if_req = 1'b0;
        ls_req = 1'b0;
        rfin   = 1'b0;
        #1;
        check_reset_outputs("reset");
        exp_last     = 1'b0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Serve one transaction. Called #1 after a rising edge in an IDLE cycle with
    // the requests already driven; returns #1 into the following IDLE cycle.
    // rfin arrives on WAIT cycle 'delay'; no_rfin leaves it low for 'delay' cycles.
    task automatic run_txn(input int delay, input logic [31:0] data, input bit no_rfin);
        bit          own;
        logic [31:0] a;
        own      = (if_req && ls_req) ? !exp_last : ls_req;
        a        = own ? ls_addr : if_addr;
        a[1:0]   = 2'b00;
        exp_last = own;
        grants.push_back(own);
        @(posedge clk);
        #1;
        check("wait_read_ce", read_ce, 1);
        check("wait_busy", busy, 1);
        check("wait_address", address, a);
        for (int w = 1; w <= delay; w++) begin
            rfin = !no_rfin && (w == delay);
            dout = (w == delay) ? data : $urandom;
            @(posedge clk);
            #1;
            if (w < delay) check("wait_hold_read_ce", read_ce, 1);
        end
        rfin           = 1'b0;
        exp_rdata[own] = no_rfin ? 32'h0 : data;
        check("resp_if_ack", if_ack, !own);
        check("resp_ls_ack", ls_ack, own);
        check("resp_if_rdata", if_rdata, exp_rdata[0]);
        check("resp_ls_rdata", ls_rdata, exp_rdata[1]);
        check("resp_read_ce", read_ce, 0);
        check("resp_err", err, no_rfin);
        check("resp_address", address, a);
        @(posedge clk);
        #1;
        if (own) ls_req = 1'b0;
        else     if_req = 1'b0;
        check("idle_acks", {if_ack, ls_ack}, 0);
        check("idle_busy", busy, 0);
        check("idle_read_ce", read_ce, 0);
        check("idle_err", err, 0);
    endtask

    initial begin
        logic [1:0] pat;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        #2;
        do_reset();

        // Single fetch, unaligned address, rfin on the 3rd WAIT cycle.
        if_req  = 1'b1;
        if_addr = 32'h0000_0107;
        run_txn(3, 32'hDEADBEEF, 1'b0);
        check("fetch_address", address, 32'h0000_0104);
        check("fetch_rdata", if_rdata, 32'hDEADBEEF);

        // Simultaneous requests twice: expect ls, if, ls, if.
        grants.delete();
        for (int r = 0; r < 2; r++) begin
            if_addr = $urandom;
            ls_addr = $urandom;
            if_req  = 1'b1;
            ls_req  = 1'b1;
            run_txn(1 + r, $urandom, 1'b0);
            run_txn(2, $urandom, 1'b0);
        end
        check("tie_order", {grants[0], grants[1], grants[2], grants[3]}, 4'b1010);

        // Stray rfin while idle must change nothing.
        rfin = 1'b1;
        dout = $urandom;
        @(posedge clk);
        #1;
        rfin = 1'b0;
        check("stray_busy", busy, 0);
        check("stray_read_ce", read_ce, 0);
        check("stray_acks", {if_ack, ls_ack}, 0);
        check("stray_rdata", {if_rdata, ls_rdata}, {exp_rdata[0], exp_rdata[1]});

        // Randomized traffic.
        for (int i = 0; i < 24; i++) begin
            pat     = 2'($urandom_range(1, 3));
            if_addr = $urandom;
            ls_addr = $urandom;
            if_req  = pat[0];
            ls_req  = pat[1];
            run_txn($urandom_range(1, 4), $urandom, 1'b0);
            if (pat == 2'b11) run_txn($urandom_range(1, 4), $urandom, 1'b0);
        end

        // Reset mid-WAIT with ls as owner: outputs clear at once, no ack.
        ls_req  = 1'b1;
        ls_addr = $urandom;
        @(posedge clk);
        #1;
        check("kill_pre_read_ce", read_ce, 1);
        #2;
        rst = 1'b0;
        #1;
        check("kill_read_ce", read_ce, 0);
        check("kill_busy", busy, 0);
        check("kill_ls_ack", ls_ack, 0);
        check("kill_rdata", {if_rdata, ls_rdata}, 0);
        ls_req       = 1'b0;
        exp_last     = 1'b0;
        exp_rdata[0] = '0;
        exp_rdata[1] = '0;
        @(posedge clk);
        #1;
        check("kill_no_ack", {if_ack, ls_ack}, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        if_req  = 1'b1;
        if_addr = $urandom;
        run_txn(2, $urandom, 1'b0);

`ifdef ROM_ARB_TIMEOUT_EN
        // rfin never comes: abort after TO WAIT cycles with zero data and err.
        ls_req  = 1'b1;
        ls_addr = $urandom;
        run_txn(TO, 32'h0, 1'b1);
        check("timeout_rdata", ls_rdata, 0);
`else
        // rfin never comes: WAIT has no bound.
        if_req  = 1'b1;
        if_addr = $urandom;
        @(posedge clk);
        #1;
        repeat (300) @(posedge clk);
        #1;
        check("unbounded_busy", busy, 1);
        check("unbounded_read_ce", read_ce, 1);
        check("unbounded_acks", {if_ack, ls_ack}, 0);
        check("unbounded_err", err, 0);
        do_reset();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
